tl_monitor: RTL and testbench
=============================

TL_MONITOR -- requirements
Module: tl_monitor

Interface
REQ-001 Parameter: CNT_W, default 8, width of the completed-cycle counter.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: La  input  2  road A light code: 00 green, 01 yellow, 10 left-turn, 11 red.
REQ-005 Port: Lb  input  2  road B light code, same encoding as La.
REQ-006 Port: clr_err  input  1  clears the sticky error flag.
REQ-007 Port: lamp_a  output  4  road A one-hot lamp drive: bit0 G, bit1 Y, bit2 L, bit3 R.
REQ-008 Port: lamp_b  output  4  road B one-hot lamp drive, same bit order.
REQ-009 Port: seq_err_a / seq_err_b  output  1 each  one-cycle pulse on an illegal road transition.
REQ-010 Port: conflict  output  1  one-cycle pulse when both roads are non-red in the same sample.
REQ-011 Port: err_sticky  output  1  latched OR of all error pulses.
REQ-012 Port: cycle_cnt  output  CNT_W  count of completed legal road-A cycles.

Function
REQ-013 All outputs SHALL be registered, reflecting the La/Lb sample from the previous edge (latency 1 cycle).
REQ-014 lamp_x SHALL be the one-hot decode of the sampled code; each code maps to exactly one lamp.
REQ-015 Each road SHALL have a tracking FSM with states UNSYNC, RED, GRN, Y1 (yellow after green), LFT, Y2 (yellow after left).
REQ-016 From UNSYNC: code 11 -> RED, code 00 -> GRN, codes 01/10 -> stay UNSYNC; no error is flagged in UNSYNC.
REQ-017 Legal moves: RED->{RED,GRN}; GRN->{GRN,Y1}; Y1->{Y1,LFT}; LFT->{LFT,Y2}; Y2->{Y2,RED}.
REQ-018 Any other observed code from a synced state SHALL pulse seq_err_x for one cycle and resync: code 11 -> RED, 00 -> GRN, otherwise UNSYNC.
REQ-019 conflict SHALL pulse whenever La != 11 and Lb != 11 in the same sample, independent of FSM state.
REQ-020 err_sticky SHALL set on any seq_err_a, seq_err_b or conflict pulse; it clears on clr_err only.
REQ-021 If clr_err and a new error occur in the same cycle, err_sticky SHALL end that cycle set (error wins).
REQ-022 cycle_cnt SHALL increment by 1 on each legal road-A Y2->RED move, and saturate at all-ones.

Reset
REQ-023 On reset: both FSMs UNSYNC, lamp_a = lamp_b = 4'b1000 (red), all error outputs 0, cycle_cnt 0.
REQ-024 Reset asserted mid-sequence SHALL override all inputs that cycle, including clr_err and errors.

Configuration
REQ-025 Macro TLM_CYCLE_CNT_EN defined: cycle_cnt behaves per REQ-022.
REQ-026 Macro TLM_CYCLE_CNT_EN undefined: the counter is not built, cycle_cnt is tied to 0, and all other behaviour is unchanged.

Structure
REQ-027 The light-code constants (G/Y/L/R), the one-hot lamp constants and the FSM state encodings SHALL live in a shared package (tlm_pkg), also used by the controller bench.
REQ-028 The per-road FSM plus decoder SHALL be sub-module tlm_road, instantiated twice; the conflict check, sticky flag and counter live in the top level.

Verification
REQ-029 Reset, then hold La=11, Lb=11 for 3 cycles -> lamp_a = lamp_b = 1000, no errors, cycle_cnt = 0.
REQ-030 Drive road A through 11,00,01,10,01,11 while Lb=11 -> lamp_a follows with 1-cycle delay, no errors, cycle_cnt = 1.
REQ-031 With road A in GRN, drive La=10 -> seq_err_a pulses once, err_sticky = 1, road A FSM goes to UNSYNC.
REQ-032 Drive La=00 and Lb=01 together -> conflict pulses, err_sticky = 1; the B FSM error is judged per REQ-016/018.
REQ-033 Assert clr_err in the same cycle as a conflict -> err_sticky stays 1; assert clr_err alone on the next cycle -> err_sticky = 0.
REQ-034 Run 256 legal cycles with CNT_W=8 -> cycle_cnt = 255 (saturates); the same test with TLM_CYCLE_CNT_EN undefined -> cycle_cnt = 0.

Source files
------------

// File: rtl/tlm_pkg.sv
// Traffic-light monitor shared types: light codes, lamp patterns, road states.
// Used by the RTL and by the controller bench.
package tlm_pkg;

  localparam logic [1:0] C_G = 2'b00;
  localparam logic [1:0] C_Y = 2'b01;
  localparam logic [1:0] C_L = 2'b10;
  localparam logic [1:0] C_R = 2'b11;

  localparam logic [3:0] LAMP_G = 4'b0001;
  localparam logic [3:0] LAMP_Y = 4'b0010;
  localparam logic [3:0] LAMP_L = 4'b0100;
  localparam logic [3:0] LAMP_R = 4'b1000;

  typedef enum logic [2:0] {
    S_UNSYNC = 3'd0,
    S_RED    = 3'd1,
    S_GRN    = 3'd2,
    S_Y1     = 3'd3,
    S_LFT    = 3'd4,
    S_Y2     = 3'd5
  } road_st_t;

  function automatic road_st_t resync(input logic [1:0] code);
    unique case (code)
      C_R:     resync = S_RED;
      C_G:     resync = S_GRN;
      default: resync = S_UNSYNC;
    endcase
  endfunction

  function automatic logic [3:0] lamp_of(input logic [1:0] code);
    unique case (code)
      C_G:     lamp_of = LAMP_G;
      C_Y:     lamp_of = LAMP_Y;
      C_L:     lamp_of = LAMP_L;
      default: lamp_of = LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/tlm_road.sv
// Per-road sequence tracker and one-hot lamp decoder.
// err_nxt/cyc_nxt are the unregistered next-cycle pulses for the top level.
module tlm_road
  import tlm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] code,
  output logic [3:0] lamp,
  output logic       seq_err,
  output logic       err_nxt,
  output logic       cyc_nxt
);

  road_st_t state;
  road_st_t state_nxt;

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    cyc_nxt   = 1'b0;
    unique case (state)
      S_UNSYNC: state_nxt = resync(code);
      S_RED: begin
        if (code == C_G) state_nxt = S_GRN;
        else if (code != C_R) err_nxt = 1'b1;
      end
      S_GRN: begin
        if (code == C_Y) state_nxt = S_Y1;
        else if (code != C_G) err_nxt = 1'b1;
      end
      S_Y1: begin
        if (code == C_L) state_nxt = S_LFT;
        else if (code != C_Y) err_nxt = 1'b1;
      end
      S_LFT: begin
        if (code == C_Y) state_nxt = S_Y2;
        else if (code != C_L) err_nxt = 1'b1;
      end
      S_Y2: begin
        if (code == C_R) begin
          state_nxt = S_RED;
          cyc_nxt   = 1'b1;
        end else if (code != C_Y) begin
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = S_UNSYNC;
    endcase
    // an illegal move drops the tracker back onto whatever the code implies
    if (err_nxt) state_nxt = resync(code);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_UNSYNC;
      lamp    <= LAMP_R;
      seq_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      lamp    <= lamp_of(code);
      seq_err <= err_nxt;
    end
  end

endmodule

// File: rtl/tl_monitor.sv
// Two-road traffic-light monitor: lamp decode, sequence/conflict checks.
// Define TLM_CYCLE_CNT_EN to build the completed road-A cycle counter.
module tl_monitor
  import tlm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       La,
  input  logic [1:0]       Lb,
  input  logic             clr_err,
  output logic [3:0]       lamp_a,
  output logic [3:0]       lamp_b,
  output logic             seq_err_a,
  output logic             seq_err_b,
  output logic             conflict,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cycle_cnt
);

  logic err_a;
  logic err_b;
  logic cyc_a;
  logic cyc_b;
  logic conf_nxt;
  logic err_any;

  tlm_road u_road_a (
    .clk     (clk),
    .reset   (reset),
    .code    (La),
    .lamp    (lamp_a),
    .seq_err (seq_err_a),
    .err_nxt (err_a),
    .cyc_nxt (cyc_a)
  );

  tlm_road u_road_b (
    .clk     (clk),
    .reset   (reset),
    .code    (Lb),
    .lamp    (lamp_b),
    .seq_err (seq_err_b),
    .err_nxt (err_b),
    .cyc_nxt (cyc_b)
  );

  assign conf_nxt = (La != C_R) && (Lb != C_R);
  assign err_any  = err_a | err_b | conf_nxt;

  // a fresh error outranks a clear arriving in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      conflict <= conf_nxt;
      if (err_any) err_sticky <= 1'b1;
      else if (clr_err) err_sticky <= 1'b0;
    end
  end

`ifdef TLM_CYCLE_CNT_EN
  logic unused_cyc;
  assign unused_cyc = cyc_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (cyc_a && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end
`else
  logic unused_cyc;
  assign unused_cyc = cyc_a ^ cyc_b;
  assign cycle_cnt  = '0;
`endif

endmodule

// File: tb/tb_tl_monitor.sv
// Directed bench for tl_monitor; counter expectations follow TLM_CYCLE_CNT_EN.
module tb_tl_monitor;
  import tlm_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       La;
  logic [1:0]       Lb;
  logic             clr_err;
  logic [3:0]       lamp_a;
  logic [3:0]       lamp_b;
  logic             seq_err_a;
  logic             seq_err_b;
  logic             conflict;
  logic             err_sticky;
  logic [CNT_W-1:0] cycle_cnt;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  tl_monitor #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .La         (La),
    .Lb         (Lb),
    .clr_err    (clr_err),
    .lamp_a     (lamp_a),
    .lamp_b     (lamp_b),
    .seq_err_a  (seq_err_a),
    .seq_err_b  (seq_err_b),
    .conflict   (conflict),
    .err_sticky (err_sticky),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cexp(input int n);
`ifdef TLM_CYCLE_CNT_EN
    cexp = (n > 255) ? 32'd255 : 32'(n);
`else
    cexp = 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] a,
                      input logic [1:0] b, input logic clr);
    reset   = rst;
    La      = a;
    Lb      = b;
    clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [3:0] la_e,
                            input logic [3:0] lb_e, input logic ea,
                            input logic eb, input logic cf, input logic st);
    check({tag, ".lamp_a"}, 32'(lamp_a), 32'(la_e));
    check({tag, ".lamp_b"}, 32'(lamp_b), 32'(lb_e));
    check({tag, ".err_a"}, 32'(seq_err_a), 32'(ea));
    check({tag, ".err_b"}, 32'(seq_err_b), 32'(eb));
    check({tag, ".conf"}, 32'(conflict), 32'(cf));
    check({tag, ".sticky"}, 32'(err_sticky), 32'(st));
    check({tag, ".cnt"}, 32'(cycle_cnt), cexp(ncyc));
  endtask

  initial begin
    // reset overrides a would-be conflict/error and clr_err
    step(1'b1, C_G, C_Y, 1'b1);
    expect_all("rst", LAMP_R, LAMP_R, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, C_R, C_R, 1'b0);
      expect_all("idle", LAMP_R, LAMP_R, 0, 0, 0, 0);
    end

    // one full legal road-A cycle
    step(1'b0, C_R, C_R, 1'b0);
    expect_all("a_r", LAMP_R, LAMP_R, 0, 0, 0, 0);
    step(1'b0, C_G, C_R, 1'b0);
    expect_all("a_g", LAMP_G, LAMP_R, 0, 0, 0, 0);
    step(1'b0, C_Y, C_R, 1'b0);
    expect_all("a_y1", LAMP_Y, LAMP_R, 0, 0, 0, 0);
    step(1'b0, C_L, C_R, 1'b0);
    expect_all("a_l", LAMP_L, LAMP_R, 0, 0, 0, 0);
    step(1'b0, C_Y, C_R, 1'b0);
    expect_all("a_y2", LAMP_Y, LAMP_R, 0, 0, 0, 0);
    step(1'b0, C_R, C_R, 1'b0);
    ncyc = 1;
    expect_all("a_done", LAMP_R, LAMP_R, 0, 0, 0, 0);

    // GRN -> left-turn is illegal; road A falls to UNSYNC
    step(1'b0, C_G, C_R, 1'b0);
    expect_all("g", LAMP_G, LAMP_R, 0, 0, 0, 0);
    step(1'b0, C_L, C_R, 1'b0);
    expect_all("g2l", LAMP_L, LAMP_R, 1, 0, 0, 1);
    check("g2l.state", 32'(dut.u_road_a.state), 32'(S_UNSYNC));
    step(1'b0, C_Y, C_R, 1'b0);
    expect_all("unsync_y", LAMP_Y, LAMP_R, 0, 0, 0, 1);
    step(1'b0, C_R, C_R, 1'b0);
    expect_all("resync_r", LAMP_R, LAMP_R, 0, 0, 0, 1);
    step(1'b0, C_R, C_R, 1'b1);
    expect_all("clr1", LAMP_R, LAMP_R, 0, 0, 0, 0);

    // conflict plus road-B RED -> yellow error
    step(1'b0, C_G, C_Y, 1'b0);
    expect_all("conf", LAMP_G, LAMP_Y, 0, 1, 1, 1);
    step(1'b0, C_G, C_L, 1'b1);
    expect_all("conf_clr", LAMP_G, LAMP_L, 0, 0, 1, 1);
    step(1'b0, C_G, C_R, 1'b1);
    expect_all("clr2", LAMP_G, LAMP_R, 0, 0, 0, 0);

    step(1'b0, C_Y, C_R, 1'b0);
    step(1'b0, C_L, C_R, 1'b0);
    step(1'b0, C_Y, C_R, 1'b0);
    step(1'b0, C_R, C_R, 1'b0);
    ncyc = 2;
    expect_all("a_done2", LAMP_R, LAMP_R, 0, 0, 0, 0);

    // drive the counter past saturation
    for (int i = 0; i < 256; i++) begin
      step(1'b0, C_G, C_R, 1'b0);
      step(1'b0, C_Y, C_R, 1'b0);
      step(1'b0, C_L, C_R, 1'b0);
      step(1'b0, C_Y, C_R, 1'b0);
      step(1'b0, C_R, C_R, 1'b0);
      ncyc++;
      check("sat.cnt", 32'(cycle_cnt), cexp(ncyc));
    end
    expect_all("sat", LAMP_R, LAMP_R, 0, 0, 0, 0);

    // mid-run reset beats an illegal move and a conflict
    step(1'b1, C_L, C_G, 1'b0);
    ncyc = 0;
    expect_all("rst2", LAMP_R, LAMP_R, 0, 0, 0, 0);
    step(1'b0, C_Y, C_R, 1'b0);
    expect_all("post_rst", LAMP_Y, LAMP_R, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
